// File: rtl/oehb_multislot.sv
// Multi-slot opaque elastic buffer: circular queue between two valid/ready channels.
// Registered outputs only; the ready path is optionally broken as well.
module oehb_multislot #(
   parameter int DATA_TYPE   = 32,
   parameter int NUM_SLOTS   = 2,
   parameter int BREAK_READY = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DATA_TYPE-1:0]             ins,
   input  logic                             ins_valid,
   output logic                             ins_ready,
   output logic [DATA_TYPE-1:0]             outs,
   output logic                             outs_valid,
   input  logic                             outs_ready,
   output logic [$clog2(NUM_SLOTS+1)-1:0]   count
);

   localparam int CW = $clog2(NUM_SLOTS + 1);
   localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam logic [PW-1:0] LAST = PW'(NUM_SLOTS - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(NUM_SLOTS);
   localparam logic BR = (BREAK_READY != 0);

   logic [DATA_TYPE-1:0] slots_q [NUM_SLOTS];
   logic [DATA_TYPE-1:0] slots_d [NUM_SLOTS];
   logic [PW-1:0]        head_q, head_d;
   logic [PW-1:0]        tail_q, tail_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 full;
   logic                 push;
   logic                 pop;

   // Handshake decode; ready is forced low while reset is asserted
   always_comb begin
      full       = (count_q == FULL_CNT);
      outs_valid = (count_q != '0);
      outs       = slots_q[head_q];
      count      = count_q;
      ins_ready  = ~rst & (~full | (~BR & outs_ready));
      push       = ins_valid & ins_ready;
      pop        = outs_valid & outs_ready;
   end

   // Next state: write at tail on push, advance head on pop, pointers wrap by compare
   always_comb begin
      slots_d = slots_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) begin
         slots_d[tail_q] = ins;
         tail_d = (tail_q == LAST) ? '0 : tail_q + PW'(1);
      end
      if (pop) begin
         head_d = (head_q == LAST) ? '0 : head_q + PW'(1);
      end
   end

   // State registers with synchronous reset that clears every slot
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slots_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slots_q[i] <= slots_d[i];
         end
      end
   end

endmodule

// File: tb/tb_oehb_multislot.sv
// Directed bench for oehb_multislot across three configurations.
// A: 2 slots ready-through, B: 3 slots ready-broken, C: 2 slots ready-broken.
module tb_oehb_multislot;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   logic [7:0] a_ins, a_outs, b_ins, b_outs, c_ins, c_outs;
   logic       a_iv, a_ir, a_ov, a_or;
   logic       b_iv, b_ir, b_ov, b_or;
   logic       c_iv, c_ir, c_ov, c_or;
   logic [1:0] a_cnt, b_cnt, c_cnt;

   always #5 clk = ~clk;

   oehb_multislot #(.DATA_TYPE(8), .NUM_SLOTS(2), .BREAK_READY(0)) u_a (
      .clk(clk), .rst(rst), .ins(a_ins), .ins_valid(a_iv), .ins_ready(a_ir),
      .outs(a_outs), .outs_valid(a_ov), .outs_ready(a_or), .count(a_cnt));

   oehb_multislot #(.DATA_TYPE(8), .NUM_SLOTS(3), .BREAK_READY(1)) u_b (
      .clk(clk), .rst(rst), .ins(b_ins), .ins_valid(b_iv), .ins_ready(b_ir),
      .outs(b_outs), .outs_valid(b_ov), .outs_ready(b_or), .count(b_cnt));

   oehb_multislot #(.DATA_TYPE(8), .NUM_SLOTS(2), .BREAK_READY(1)) u_c (
      .clk(clk), .rst(rst), .ins(c_ins), .ins_valid(c_iv), .ins_ready(c_ir),
      .outs(c_outs), .outs_valid(c_ov), .outs_ready(c_or), .count(c_cnt));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      a_iv = 0; a_or = 0; a_ins = 0;
      b_iv = 0; b_or = 0; b_ins = 0;
      c_iv = 0; c_or = 0; c_ins = 0;
   endtask

   initial begin
      logic [7:0] nxt;
      logic [7:0] rcv;
      logic [7:0] held;
      logic       stall;
      logic       done;

      // 1: reset with random inputs
      rst = 1;
      a_ins = 8'($urandom); a_iv = 1; a_or = 1;
      b_ins = 8'($urandom); b_iv = 1; b_or = 1;
      c_ins = 8'($urandom); c_iv = 1; c_or = 1;
      #1;
      chk("rst_a_ir_comb", a_ir, 0);
      chk("rst_b_ir_comb", b_ir, 0);
      for (int k = 0; k < 2; k++) begin
         tick();
         a_ins = 8'($urandom); b_ins = 8'($urandom); c_ins = 8'($urandom);
         #1;
         chk("rst_a_ov", a_ov, 0);
         chk("rst_a_cnt", a_cnt, 0);
         chk("rst_a_ir", a_ir, 0);
         chk("rst_a_outs", a_outs, 0);
         chk("rst_b_ov", b_ov, 0);
         chk("rst_b_cnt", b_cnt, 0);
         chk("rst_c_ir", c_ir, 0);
         chk("rst_c_outs", c_outs, 0);
      end
      rst = 0;
      idle();
      #1;
      chk("rel_a_ir", a_ir, 1);
      chk("rel_b_ir", b_ir, 1);
      chk("rel_c_ir", c_ir, 1);

      // 2: latency on A
      a_or = 1; a_iv = 1; a_ins = 8'hA5;
      #1;
      chk("lat_ov_t", a_ov, 0);
      chk("lat_outs_t", a_outs, 0);
      tick();
      a_iv = 0;
      #1;
      chk("lat_ov_t1", a_ov, 1);
      chk("lat_outs_t1", a_outs, 8'hA5);
      chk("lat_cnt_t1", a_cnt, 1);
      tick();
      chk("lat_drain_ov", a_ov, 0);
      chk("lat_drain_cnt", a_cnt, 0);
      idle();

      // 3: fill/drain on B
      b_iv = 1; b_ins = 1; tick();
      b_ins = 2; tick();
      b_ins = 3; tick();
      b_ins = 4;
      #1;
      chk("fill_cnt", b_cnt, 3);
      chk("fill_ir", b_ir, 0);
      chk("fill_head", b_outs, 1);
      tick();
      b_iv = 0;
      chk("fill_hold_cnt", b_cnt, 3);
      chk("fill_hold_outs", b_outs, 1);
      b_or = 1;
      tick();
      chk("drain1_outs", b_outs, 2);
      chk("drain1_cnt", b_cnt, 2);
      tick();
      chk("drain2_outs", b_outs, 3);
      chk("drain2_cnt", b_cnt, 1);
      tick();
      chk("drain3_cnt", b_cnt, 0);
      chk("drain3_ov", b_ov, 0);
      idle();

      // 4a: full-concurrent on A (ready passes through)
      a_iv = 1; a_ins = 8'h11; tick();
      a_ins = 8'h22; tick();
      a_ins = 8'h33;
      #1;
      chk("fc_a_cnt_full", a_cnt, 2);
      chk("fc_a_ir_stall", a_ir, 0);
      a_or = 1;
      #1;
      chk("fc_a_ir_go", a_ir, 1);
      tick();
      chk("fc_a_cnt1", a_cnt, 2);
      chk("fc_a_outs1", a_outs, 8'h22);
      a_ins = 8'h44;
      tick();
      chk("fc_a_cnt2", a_cnt, 2);
      chk("fc_a_outs2", a_outs, 8'h33);
      a_iv = 0;
      tick();
      chk("fc_a_outs3", a_outs, 8'h44);
      chk("fc_a_cnt3", a_cnt, 1);
      tick();
      chk("fc_a_cnt4", a_cnt, 0);
      idle();

      // 4b: same stimulus on C (ready broken)
      c_iv = 1; c_ins = 8'h61; tick();
      c_ins = 8'h62; tick();
      c_ins = 8'h63; c_or = 1;
      #1;
      chk("fc_c_ir_full", c_ir, 0);
      tick();
      chk("fc_c_cnt1", c_cnt, 1);
      chk("fc_c_outs1", c_outs, 8'h62);
      chk("fc_c_ir1", c_ir, 1);
      tick();
      chk("fc_c_cnt2", c_cnt, 1);
      chk("fc_c_outs2", c_outs, 8'h63);
      c_iv = 0;
      tick();
      chk("fc_c_cnt3", c_cnt, 0);
      idle();

      // 5: wrap on B with random output stalls
      nxt = 0; rcv = 0; held = 0; stall = 0; done = 0;
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
         b_iv = (nxt < 10);
         b_ins = nxt;
         b_or = 1'($urandom);
         #1;
         if (stall) begin
            chk("wrap_stable", b_outs, held);
         end
         stall = b_ov & ~b_or;
         held = b_outs;
         if (b_ov && b_or) begin
            chk("wrap_order", b_outs, rcv);
            rcv++;
         end
         if (b_iv && b_ir) nxt++;
         tick();
         if (rcv == 10) done = 1;
      end
      chk("wrap_done", done, 1);
      chk("wrap_empty", b_cnt, 0);
      idle();

      // 6: mid-stream reset on A
      a_iv = 1; a_ins = 8'h71; tick();
      a_ins = 8'h72; tick();
      chk("mr_pre_cnt", a_cnt, 2);
      rst = 1; a_ins = 8'h73; a_or = 1;
      #1;
      chk("mr_ir_rst", a_ir, 0);
      tick();
      rst = 0; a_iv = 0; a_or = 0;
      #1;
      chk("mr_cnt", a_cnt, 0);
      chk("mr_ov", a_ov, 0);
      chk("mr_outs", a_outs, 0);
      a_iv = 1; a_ins = 8'h5A;
      tick();
      a_iv = 0;
      chk("mr_new_outs", a_outs, 8'h5A);
      chk("mr_new_cnt", a_cnt, 1);
      a_or = 1;
      tick();
      chk("mr_drain_cnt", a_cnt, 0);
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
